// File: rtl/alu_if.sv
// ALU request/response bus.
//   master (requester): drives alu_a, alu_b, alu_op, alu_en; receives alu_res, alu_ack
//   slave  (ALU)      : the opposite directions
interface alu_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_op;
   logic             alu_en;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ack;

   modport master (output alu_a, alu_b, alu_op, alu_en, input alu_res, alu_ack);
   modport slave  (input alu_a, alu_b, alu_op, alu_en, output alu_res, alu_ack);
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: on an accepted start, latches two operands and an op mask,
// then issues every enabled op code (ascending) to the ALU one at a time,
// capturing each result into an 8-entry buffer. Ops with no ack within
// TIMEOUT request cycles are abandoned and flagged in err_mask.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             begin a sequence (ignored unless idle)
//   a_in, b_in        operands, op_mask selects ops; sampled on accepted start
//   alu               ALU bus (master side)
//   busy, done        not-idle flag, one-cycle end-of-sequence pulse
//   err_mask          ops that timed out in the last sequence
//   rd_idx            buffer read index; rd_data / rd_valid combinational read
module alu_op_sequencer #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [7:0]       op_mask,
   alu_if.master            alu,
   output logic             busy,
   output logic             done,
   output logic [7:0]       err_mask,
   input  logic [2:0]       rd_idx,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam int CW = $clog2(TIMEOUT + 1);
   // counter value seen in the last permitted REQ cycle
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   logic [1:0]            state_q, state_d;
   logic [WIDTH-1:0]      alu_a_q, alu_a_d;
   logic [WIDTH-1:0]      alu_b_q, alu_b_d;
   logic [2:0]            alu_op_q, alu_op_d;
   logic [7:0]            mask_q, mask_d;
   logic [7:0]            err_q, err_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [7:0][WIDTH-1:0] rbuf_q, rbuf_d;
   logic [7:0]            vld_q, vld_d;

   logic [3:0] first_op;   // {found, index} of lowest bit in op_mask
   logic [3:0] next_op;    // {found, index} of lowest mask bit above alu_op
   logic       cnt_last;

   // Priority encoder: returns {found, index of lowest set bit}.
   function automatic logic [3:0] lowest(input logic [7:0] m);
      lowest = 4'b0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) lowest = {1'b1, 3'(i)};
   endfunction

   always_comb begin
      first_op = lowest(op_mask);
      next_op  = lowest(mask_q & (8'hFE << alu_op_q));
      cnt_last = (cnt_q == CNT_LAST);

      state_d  = state_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      mask_d   = mask_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      rbuf_d   = rbuf_q;
      vld_d    = vld_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               alu_a_d = a_in;
               alu_b_d = b_in;
               mask_d  = op_mask;
               err_d   = '0;
               vld_d   = '0;
               rbuf_d  = '0;
               cnt_d   = '0;
               if (first_op[3]) begin
                  state_d  = REQ;
                  alu_op_d = first_op[2:0];
               end else begin
                  state_d  = DONE;
                  alu_op_d = '0;
               end
            end
         end
         REQ: begin
            cnt_d = cnt_q + CW'(1);
            // ack takes priority over a timeout landing in the same cycle
            if (alu.alu_ack || cnt_last) begin
               if (alu.alu_ack) begin
                  rbuf_d[alu_op_q] = alu.alu_res;
                  vld_d[alu_op_q]  = 1'b1;
               end else begin
                  rbuf_d[alu_op_q] = '0;
                  err_d[alu_op_q]  = 1'b1;
               end
               state_d = next_op[3] ? GAP : DONE;
            end
         end
         GAP: begin
            alu_op_d = next_op[2:0];
            cnt_d    = '0;
            state_d  = REQ;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         mask_q   <= '0;
         err_q    <= '0;
         cnt_q    <= '0;
         rbuf_q   <= '0;
         vld_q    <= '0;
      end else begin
         state_q  <= state_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         mask_q   <= mask_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
         rbuf_q   <= rbuf_d;
         vld_q    <= vld_d;
      end
   end

   assign alu.alu_a  = alu_a_q;
   assign alu.alu_b  = alu_b_q;
   assign alu.alu_op = alu_op_q;
   assign alu.alu_en = (state_q == REQ);

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign err_mask = err_q;
   assign rd_data  = rbuf_q[rd_idx];
   assign rd_valid = vld_q[rd_idx];

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic [7:0]   op_mask = '0;
   logic         busy, done;
   logic [7:0]   err_mask;
   logic [2:0]   rd_idx = '0;
   logic [W-1:0] rd_data;
   logic         rd_valid;

   always #5 clk = ~clk;

   alu_if #(.WIDTH(W)) alu_bus ();

   alu_op_sequencer #(.WIDTH(W), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
      .op_mask(op_mask), .alu(alu_bus), .busy(busy), .done(done),
      .err_mask(err_mask), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid)
   );

   // ALU model: res = a+b+op; op i acks in its dly[i]-th request cycle, 0 = never
   int dly [8];
   int en_cnt = 0;
   int cyc = 0;
   int c0 = 0;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      en_cnt <= alu_bus.alu_en ? en_cnt + 1 : 0;
   end

   assign alu_bus.alu_res = alu_bus.alu_a + alu_bus.alu_b + W'(alu_bus.alu_op);
   assign alu_bus.alu_ack = alu_bus.alu_en && (dly[alu_bus.alu_op] != 0) &&
                            (en_cnt == dly[alu_bus.alu_op] - 1);

   // scoreboard
   typedef struct { int op; int len; } req_t;
   typedef struct { int op; logic [W-1:0] a; logic [W-1:0] b; } hs_t;
   typedef struct { int cyc; logic [7:0] err; } done_t;
   req_t  req_q [$];
   hs_t   hs_q [$];
   done_t done_q [$];

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // monitor: pops expectations whenever the DUT finishes a request,
   // completes a handshake, or pulses done
   initial begin
      int   run = 0;
      int   last_op = 0;
      logic prev_en = 1'b0;
      req_t r;
      hs_t h;
      done_t d;
      forever begin
         @(negedge clk);
         if (alu_bus.alu_en === 1'b1) begin
            run++;
            last_op = int'(alu_bus.alu_op);
         end else if (prev_en === 1'b1) begin
            if (req_q.size() == 0) chk("req_unexpected", 64'(last_op), 64'hFFFF);
            else begin
               r = req_q.pop_front();
               chk("req_op", 64'(last_op), 64'(r.op));
               chk("req_len", 64'(run), 64'(r.len));
            end
            run = 0;
         end
         prev_en = alu_bus.alu_en;
         if (alu_bus.alu_en === 1'b1 && alu_bus.alu_ack === 1'b1) begin
            if (hs_q.size() == 0) chk("hs_unexpected", 64'(alu_bus.alu_op), 64'hFFFF);
            else begin
               h = hs_q.pop_front();
               chk("hs_op", 64'(alu_bus.alu_op), 64'(h.op));
               chk("hs_a", 64'(alu_bus.alu_a), 64'(h.a));
               chk("hs_b", 64'(alu_bus.alu_b), 64'(h.b));
            end
         end
         if (done !== 1'b0) begin
            if (done_q.size() == 0) chk("done_unexpected", 64'(cyc - c0), 64'hFFFF);
            else begin
               d = done_q.pop_front();
               chk("done_cycle", 64'(cyc - c0), 64'(d.cyc));
               chk("done_err", 64'(err_mask), 64'(d.err));
            end
         end
      end
   end

   task automatic exp_op(input int op, input int len, input bit acked,
                         input logic [W-1:0] a, input logic [W-1:0] b);
      req_t r;
      hs_t h;
      r.op = op; r.len = len;
      req_q.push_back(r);
      if (acked) begin
         h.op = op; h.a = a; h.b = b;
         hs_q.push_back(h);
      end
   endtask

   task automatic exp_done(input int c, input logic [7:0] e);
      done_t d;
      d.cyc = c; d.err = e;
      done_q.push_back(d);
   endtask

   task automatic go(input logic [W-1:0] a, input logic [W-1:0] b, input logic [7:0] m);
      @(negedge clk);
      a_in = a; b_in = b; op_mask = m; start = 1'b1; c0 = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (busy !== 1'b0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_terminated"}, 64'(k < 200), 64'd1);
   endtask

   task automatic chk_buf(input int idx, input logic [W-1:0] data, input logic vld);
      rd_idx = 3'(idx);
      #1;
      chk($sformatf("buf%0d_data", idx), 64'(rd_data), 64'(data));
      chk($sformatf("buf%0d_valid", idx), 64'(rd_valid), 64'(vld));
   endtask

   localparam logic [W-1:0] A = 32'h0000_00FF;
   localparam logic [W-1:0] B = 32'h0000_000F;

   initial begin
      for (int i = 0; i < 8; i++) dly[i] = 1;

      // reset state
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_en", 64'(alu_bus.alu_en), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_err", 64'(err_mask), 64'd0);
      chk("rst_a", 64'(alu_bus.alu_a), 64'd0);
      chk("rst_op", 64'(alu_bus.alu_op), 64'd0);
      for (int i = 0; i < 8; i++) chk_buf(i, '0, 1'b0);
      rst = 1'b0;

      // all ops, combinational ack
      for (int i = 0; i < 8; i++) exp_op(i, 1, 1'b1, A, B);
      exp_done(16, 8'h00);
      go(A, B, 8'hFF);
      chk("c1_en", 64'(alu_bus.alu_en), 64'd1);
      chk("c1_busy", 64'(busy), 64'd1);
      chk("c1_op", 64'(alu_bus.alu_op), 64'd0);
      wait_idle("all");
      for (int i = 0; i < 8; i++) chk_buf(i, 32'h10E + 32'(i), 1'b1);

      // sparse mask
      exp_op(0, 1, 1'b1, A, B);
      exp_op(7, 1, 1'b1, A, B);
      exp_done(4, 8'h00);
      go(A, B, 8'h81);
      wait_idle("sparse");
      chk_buf(0, 32'h10E, 1'b1);
      chk_buf(7, 32'h115, 1'b1);
      for (int i = 1; i < 7; i++) chk_buf(i, '0, 1'b0);

      // delayed ack
      dly[2] = 3;
      exp_op(2, 3, 1'b1, A, B);
      exp_done(4, 8'h00);
      go(A, B, 8'h04);
      wait_idle("delayed");
      chk_buf(2, 32'h110, 1'b1);

      // timeout on op 3
      dly[2] = 1; dly[3] = 0;
      exp_op(2, 1, 1'b1, A, B);
      exp_op(3, 16, 1'b0, A, B);
      exp_done(19, 8'h08);
      go(A, B, 8'h0C);
      wait_idle("timeout");
      chk("timeout_err", 64'(err_mask), 64'h08);
      chk_buf(3, '0, 1'b0);
      chk_buf(2, 32'h110, 1'b1);

      // empty mask: clears previous errors and entries
      exp_done(1, 8'h00);
      go(A, B, 8'h00);
      wait_idle("empty");
      chk("empty_err", 64'(err_mask), 64'h00);
      chk_buf(2, '0, 1'b0);

      // ack in the last permitted cycle, plus a start while busy
      dly[3] = 16;
      exp_op(3, 16, 1'b1, A, B);
      exp_done(17, 8'h00);
      go(A, B, 8'h08);
      repeat (3) @(negedge clk);
      a_in = 32'hDEAD_0000; op_mask = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_a", 64'(alu_bus.alu_a), 64'(A));
      chk("busy_start_op", 64'(alu_bus.alu_op), 64'd3);
      wait_idle("edge_ack");
      chk_buf(3, 32'h111, 1'b1);
      chk_buf(0, '0, 1'b0);

      // reset during REQ of op 4
      dly[3] = 1; dly[4] = 0;
      for (int i = 0; i < 4; i++) exp_op(i, 1, 1'b1, A, B);
      exp_op(4, 3, 1'b0, A, B);
      go(A, B, 8'hFF);
      begin
         int k = 0;
         while (!(alu_bus.alu_en === 1'b1 && alu_bus.alu_op == 3'd4) && k < 100) begin
            @(negedge clk);
            k++;
         end
         chk("reach_op4", 64'(k < 100), 64'd1);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_en", 64'(alu_bus.alu_en), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_done", 64'(done), 64'd0);
      for (int i = 0; i < 8; i++) chk_buf(i, '0, 1'b0);
      repeat (3) @(negedge clk);
      dly[4] = 1;

      // normal run after reset
      exp_op(0, 1, 1'b1, A, B);
      exp_op(7, 1, 1'b1, A, B);
      exp_done(4, 8'h00);
      go(A, B, 8'h81);
      wait_idle("post_rst");
      chk_buf(0, 32'h10E, 1'b1);
      chk_buf(7, 32'h115, 1'b1);

      repeat (4) @(negedge clk);
      chk("req_q_empty", 64'(req_q.size()), 64'd0);
      chk("hs_q_empty", 64'(hs_q.size()), 64'd0);
      chk("done_q_empty", 64'(done_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Bus initiator that drives the ALU's `en`/`op`/`ack` handshake from hardware rather than from a bench. On a `start` pulse it latches two operands and an 8-bit op mask, then issues each enabled op code (000→111, ascending) to the ALU one at a time. For each op it waits for `ack` and stores the result in an 8-entry result buffer. Ops that never return `ack` are recorded as timed out. The block sits between control logic and the ALU, and is the requesting end of the ALU interface.

## Interface
- `WIDTH`, 32, operand/result width
- `TIMEOUT`, 16, maximum REQ cycles per op before the op is abandoned (≥1)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle request to begin a sequence; ignored unless idle
- `a_in`, `b_in`  in  WIDTH  operands, sampled on the accepted `start`
- `op_mask`  in  8  bit i set → issue op i; sampled on the accepted `start`
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU
- `alu_op`  out  3  registered op code to the ALU
- `alu_en`  out  1  request to the ALU
- `alu_res`  in  WIDTH  ALU result
- `alu_ack`  in  1  ALU acknowledge; may be combinational from `alu_en`
- `busy`  out  1  high whenever the state is not IDLE
- `done`  out  1  one-cycle pulse at the end of a sequence
- `err_mask`  out  8  bit i set → op i timed out in the last sequence
- `rd_idx`  in  3  result buffer read index
- `rd_data`  out  WIDTH  buffer entry selected by `rd_idx`; combinational read
- `rd_valid`  out  1  selected entry was captured from an acked op

## Operation
- States: IDLE, REQ, GAP, DONE.
- IDLE:
  - `start=1`: latch the operands into `alu_a`/`alu_b` and latch the mask.
  - Clear all valid bits and `err_mask`.
  - Find the lowest set mask bit. If one exists, go to REQ with `alu_op` set to it; if the mask is 0, go to DONE.
- REQ:
  - `alu_en=1`; the timeout counter increments each cycle.
  - `alu_ack=1`: write `alu_res` to `buf[alu_op]` and set its valid bit.
  - Counter reaches `TIMEOUT` with no ack: set `err_mask[alu_op]`, write 0 to the entry, leave its valid bit clear.
  - If ack arrives in the same cycle the counter reaches `TIMEOUT`, ack wins: no error.
  - On either exit, go to GAP if any higher mask bit remains, else go to DONE.
- GAP:
  - `alu_en=0` for exactly one cycle.
  - `alu_op` advances to the next set mask bit above the current one, and the counter clears.
  - Then go to REQ.
- DONE: `done=1` for one cycle, then go to IDLE.
- `alu_ack` outside REQ is ignored.
- `start` while not IDLE is ignored.
- `rd_data`/`rd_valid` are readable at any time and hold their values until the next accepted `start` or reset.

## Timing
- Reset values:
  - state IDLE
  - `alu_a`, `alu_b`, `alu_op`, `alu_en`, `busy`, `done`, `err_mask` all 0
  - all buffer entries 0 with valid bits clear, so `rd_data=0` and `rd_valid=0`
- Reset mid-sequence: at the edge where `rst=1`, all of the above are forced; `alu_en` is low from the following cycle and no `done` is produced.
- Cycle 0 = `start` accepted. Cycle 1: REQ, `alu_en=1`, `busy=1`.
- Combinational ack costs 2 cycles per op (REQ+GAP); the last op goes REQ→DONE.
- Combinational ack with n enabled ops: `done` in cycle 2n; `busy` is high for cycles 1..2n; IDLE in cycle 2n+1.
- Timed-out op: REQ lasts exactly `TIMEOUT` cycles.
- Mask 0: DONE in cycle 1, `done` in cycle 1, `err_mask=0`.
- `alu_a`, `alu_b` and `alu_op` are stable for the whole REQ.

## Test plan
The bench ALU model returns `res=a+b+op`.

- Reset/all ops, combinational ack:
  - Stimulus: rst for 2 cycles, then `start` with a=0x000000FF, b=0x0000000F, mask=0xFF.
  - `alu_op` steps 0..7, each with a 1-cycle `alu_en` pulse separated by 1 low cycle.
  - `done` in cycle 16.
  - buf[0]=0x10E … buf[7]=0x115, all valid, `err_mask=0`.
- Sparse mask: mask=0x81 → only ops 0 and 7 are issued.
  - `done` in cycle 4.
  - buf[0]=0x10E and buf[7]=0x115 valid; entries 1..6 have `rd_valid=0`.
- Delayed ack:
  - Responder acks 3 cycles after `en` rises, mask=0x04.
  - REQ holds for 3 cycles; buf[2]=0x110; `done` in cycle 4.
- Timeout: no ack for op 3, mask=0x0C, `TIMEOUT=16`.
  - REQ for op 3 lasts 16 cycles; `err_mask=0x08`.
  - buf[3]=0 with `rd_valid=0`; buf[2]=0x110 valid.
- Boundary:
  - Ack arriving exactly in the 16th REQ cycle is captured, with no error.
  - `start` pulsed while busy has no effect.
  - mask=0x00 gives `done` in cycle 1.
- Reset mid-sequence: assert rst during REQ of op 4 of a mask=0xFF sequence.
  - Next cycle: `alu_en=0`, `busy=0`, all `rd_valid=0`, no `done` pulse.
  - A new `start` then runs normally.
